// File: rtl/pc_unit.sv
// Program-counter unit: sequential, branch, jump, call and return selection
// with a circular return-address stack feeding return targets.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] INC          = WIDTH'(1),
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc_out,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  localparam logic [2:0] OP_BR   = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] top;
  logic [PW-1:0]    ptr_nx;
  logic [PW-1:0]    ptr_pv;
  logic             empty;
  logic             full;
  logic             push;
  logic             is_br;
  logic             is_jmp;
  logic             is_call;
  logic             is_ret;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_MAX);
  assign is_br   = (op == OP_BR);
  assign is_jmp  = (op == OP_JMP);
  assign is_call = (op == OP_CALL);
  assign is_ret  = (op == OP_RET);

  // ptr_q names the next free slot; the top entry sits one below it
  always_comb begin
    seq_pc = pc_q + INC;
    ptr_nx = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
    ptr_pv = (ptr_q == '0) ? PTR_MAX : ptr_q - 1'b1;
    top    = ras_q[ptr_pv];
  end

  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    push  = 1'b0;
    if (!stall) begin
      pc_d = seq_pc;
      unique case (1'b1)
        is_br:   pc_d = pc_q + offset;
        is_jmp:  pc_d = target;
        is_call: begin
          push  = 1'b1;
          pc_d  = target;
          ptr_d = ptr_nx;
          if (full) ovf_d = 1'b1;
          else      cnt_d = cnt_q + 1'b1;
        end
        is_ret: begin
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            pc_d  = top;
            ptr_d = ptr_pv;
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // A full stack overwrites its oldest entry, which is the slot at ptr_q
  always_ff @(posedge clk) begin
    if (push) ras_q[ptr_q] <= seq_pc;
  end

  assign pc_out    = pc_q;
  assign ras_empty = empty;
  assign ras_full  = full;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: driver queues expected state per cycle,
// a negedge monitor pops and compares.
module tb_pc_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic        e;
    logic        f;
    logic        o;
    logic        u;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  op;
  logic [31:0] offset;
  logic [31:0] target;
  logic [31:0] pc_out;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_unf;

  int total = 0;
  int bad   = 0;
  int vec   = 0;
  exp_t q[$];

  pc_unit #(
    .WIDTH(32),
    .INC(32'd1),
    .RESET_VECTOR(32'd0),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .op(op),
    .offset(offset),
    .target(target),
    .pc_out(pc_out),
    .ras_empty(ras_empty),
    .ras_full(ras_full),
    .ras_ovf(ras_ovf),
    .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input exp_t x);
    exp_t a;
    a = '{pc: pc_out, e: ras_empty, f: ras_full,
          o: ras_ovf, u: ras_unf};
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got pc=%h e=%b f=%b o=%b u=%b want pc=%h e=%b f=%b o=%b u=%b",
               name, a.pc, a.e, a.f, a.o, a.u, x.pc, x.e, x.f, x.o, x.u);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t x;
      x = q.pop_front();
      check($sformatf("vec%0d", vec), x);
      vec++;
    end
  end

  task automatic step(input logic s, input logic [2:0] o,
                      input logic [31:0] off, input logic [31:0] tg,
                      input logic [31:0] epc, input logic ee,
                      input logic ef, input logic eo, input logic eu);
    stall  = s;
    op     = o;
    offset = off;
    target = tg;
    @(posedge clk);
    q.push_back('{pc: epc, e: ee, f: ef, o: eo, u: eu});
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; op = 3'b000;
    offset = '0; target = '0;
    #12;
    check("reset", '{pc: 32'h0, e: 1'b1, f: 1'b0, o: 1'b0, u: 1'b0});
    rst = 1'b0;
    // sequential and branch/wrap
    step(0, 3'b000, 0, 0, 32'h1, 1, 0, 0, 0);
    step(0, 3'b000, 0, 0, 32'h2, 1, 0, 0, 0);
    step(0, 3'b000, 0, 0, 32'h3, 1, 0, 0, 0);
    step(0, 3'b010, 0, 32'h10, 32'h10, 1, 0, 0, 0);
    step(0, 3'b001, 32'hFFFF_FFF8, 0, 32'h8, 1, 0, 0, 0);
    step(0, 3'b010, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 0);
    step(0, 3'b000, 0, 0, 32'h0, 1, 0, 0, 0);
    // call / return
    step(0, 3'b010, 0, 32'h20, 32'h20, 1, 0, 0, 0);
    step(0, 3'b011, 0, 32'h100, 32'h100, 0, 0, 0, 0);
    step(0, 3'b000, 0, 0, 32'h101, 0, 0, 0, 0);
    step(0, 3'b000, 0, 0, 32'h102, 0, 0, 0, 0);
    step(0, 3'b100, 0, 0, 32'h21, 1, 0, 0, 0);
    // overflow then drain to underflow
    step(0, 3'b010, 0, 32'h0, 32'h0, 1, 0, 0, 0);
    step(0, 3'b011, 0, 32'h10, 32'h10, 0, 0, 0, 0);
    step(0, 3'b011, 0, 32'h20, 32'h20, 0, 0, 0, 0);
    step(0, 3'b011, 0, 32'h30, 32'h30, 0, 0, 0, 0);
    step(0, 3'b011, 0, 32'h40, 32'h40, 0, 1, 0, 0);
    step(0, 3'b011, 0, 32'h50, 32'h50, 0, 1, 1, 0);
    step(0, 3'b100, 0, 0, 32'h41, 0, 0, 0, 0);
    step(0, 3'b100, 0, 0, 32'h31, 0, 0, 0, 0);
    step(0, 3'b100, 0, 0, 32'h21, 0, 0, 0, 0);
    step(0, 3'b100, 0, 0, 32'h11, 1, 0, 0, 0);
    step(0, 3'b100, 0, 0, 32'h12, 1, 0, 0, 1);
    step(0, 3'b000, 0, 0, 32'h13, 1, 0, 0, 0);
    // stall holds everything
    step(0, 3'b010, 0, 32'h50, 32'h50, 1, 0, 0, 0);
    step(1, 3'b010, 0, 32'h999, 32'h50, 1, 0, 0, 0);
    step(1, 3'b010, 0, 32'h999, 32'h50, 1, 0, 0, 0);
    step(1, 3'b010, 0, 32'h999, 32'h50, 1, 0, 0, 0);
    step(1, 3'b100, 0, 0, 32'h50, 1, 0, 0, 0);
    step(1, 3'b011, 0, 32'h777, 32'h50, 1, 0, 0, 0);
    step(0, 3'b010, 0, 32'h999, 32'h999, 1, 0, 0, 0);
    // back-to-back call/ret, reserved ops
    step(0, 3'b011, 0, 32'h200, 32'h200, 0, 0, 0, 0);
    step(0, 3'b100, 0, 0, 32'h99A, 1, 0, 0, 0);
    step(0, 3'b101, 32'h40, 32'h40, 32'h99B, 1, 0, 0, 0);
    step(0, 3'b111, 32'h40, 32'h40, 32'h99C, 1, 0, 0, 0);
    // async reset after two calls
    step(0, 3'b011, 0, 32'h300, 32'h300, 0, 0, 0, 0);
    step(0, 3'b011, 0, 32'h400, 32'h400, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst", '{pc: 32'h0, e: 1'b1, f: 1'b0, o: 1'b0, u: 1'b0});
    #1;
    rst = 1'b0;
    step(0, 3'b000, 0, 0, 32'h1, 1, 0, 0, 0);
    step(0, 3'b100, 0, 0, 32'h2, 1, 0, 0, 1);
    step(0, 3'b000, 0, 0, 32'h3, 1, 0, 0, 0);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
